// File: rtl/scan_select_if.sv
// Control/status bundle between a scan controller and scan_select_seq.
// No handshake: run/mask/dwell are levels, sel/en/tick/busy are registered status.
interface scan_select_if #(
    parameter int DWELL_W = 16
);
    logic               run;
    logic [3:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         sel;
    logic               en;
    logic               tick;
    logic               busy;

    modport master (
        output run, mask, dwell,
        input  sel, en, tick, busy
    );

    modport slave (
        input  run, mask, dwell,
        output sel, en, tick, busy
    );
endinterface

// File: rtl/scan_select_seq.sv
// Round-robin 4-channel decoder sequencer: BLANK_CYC cycles en low, then max(dwell,1) cycles en high.
// Outputs registered (one-edge latency from inputs); no backpressure, run=0 stops on the next edge.
module scan_select_seq #(
    parameter int DWELL_W   = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    scan_select_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DWELL = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] BLANK_LD = DWELL_W'(BLANK_CYC - 1);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;
    logic               en_q, en_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;

    logic [1:0]         lowest_ch;
    logic [1:0]         next_ch;
    logic [DWELL_W-1:0] dwell_ld;

    // Later loop iterations override earlier ones, so the highest-priority hit is visited last.
    always_comb begin
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mask[i]) lowest_ch = 2'(i);
        end
        next_ch = sel_q;
        for (int k = 4; k >= 1; k--) begin
            if (bus.mask[sel_q + 2'(k)]) next_ch = sel_q + 2'(k);
        end
        dwell_ld = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        if (!bus.run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.mask != 4'd0) begin
                        state_d = BLANK;
                        sel_d   = lowest_ch;
                        cnt_d   = BLANK_LD;
                    end
                end
                BLANK: begin
                    if (cnt_q == '0) begin
                        state_d = DWELL;
                        cnt_d   = dwell_ld;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DWELL: begin
                    if (cnt_q == '0) begin
                        if (bus.mask == 4'd0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = BLANK;
                            sel_d   = next_ch;
                            tick_d  = 1'b1;
                            cnt_d   = BLANK_LD;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == IDLE) cnt_d = '0;
        en_d   = (state_d == DWELL);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'd0;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.en   = en_q;
    assign bus.tick = tick_q;
    assign bus.busy = busy_q;
endmodule
